// File: rtl/ctrl_pipe.sv
// rtl/ctrl_pipe.sv - pipelined RV32I(+M) control unit with ID/EX register and flow control
module ctrl_pipe #(
    parameter int MDU_EN  = 1,
    parameter int MDU_LAT = 4,
    parameter int CNT_W   = 6
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        id_valid,
    output logic        id_ready,
    input  logic [31:0] id_instr,
    input  logic        ex_ready,
    input  logic        flush,
    output logic        ex_valid,
    output logic [4:0]  ex_rd,
    output logic [4:0]  ex_rs1,
    output logic [4:0]  ex_rs2,
    output logic        ex_RegWrite,
    output logic        ex_MemWrite,
    output logic        ex_MemRead,
    output logic        ex_ALUSrc,
    output logic [5:0]  ex_EXTOp,
    output logic [4:0]  ex_ALUOp,
    output logic [4:0]  ex_NPCOp,
    output logic [1:0]  ex_WDSel,
    output logic        ex_mdu,
    output logic [2:0]  ex_MDUOp,
    output logic        ex_illegal
);
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_L    = 7'b0000011;
    localparam logic [6:0] OP_S    = 7'b0100011;
    localparam logic [6:0] OP_B    = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_LUI  = 7'b0110111;

    localparam logic [5:0] EXT_SHAMT = 6'b100000;
    localparam logic [5:0] EXT_I     = 6'b010000;
    localparam logic [5:0] EXT_S     = 6'b001000;
    localparam logic [5:0] EXT_B     = 6'b000100;
    localparam logic [5:0] EXT_U     = 6'b000010;
    localparam logic [5:0] EXT_J     = 6'b000001;

    localparam logic [4:0] ALU_LUI = 5'b00001;
    localparam logic [4:0] ALU_ADD = 5'b00011;

    localparam logic [4:0] NPC_BR   = 5'd1;
    localparam logic [4:0] NPC_JAL  = 5'd2;
    localparam logic [4:0] NPC_JALR = 5'd4;

    localparam logic [1:0] WD_MEM = 2'b01;
    localparam logic [1:0] WD_PC  = 2'b10;

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MDU_LAT - 1);

    typedef struct packed {
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       regw;
        logic       memw;
        logic       memr;
        logic       alusrc;
        logic [5:0] ext;
        logic [4:0] alu;
        logic [4:0] npc;
        logic [1:0] wd;
        logic       mdu;
        logic [2:0] mduop;
        logic       ill;
    } ctl_t;

    function automatic logic [4:0] alu_of(input logic [2:0] f3, input logic alt);
        case (f3)
            3'd0:    alu_of = alt ? 5'b00100 : 5'b00011;
            3'd1:    alu_of = 5'b01111;
            3'd2:    alu_of = 5'b01010;
            3'd3:    alu_of = 5'b01011;
            3'd4:    alu_of = 5'b01100;
            3'd5:    alu_of = alt ? 5'b10001 : 5'b10000;
            3'd6:    alu_of = 5'b01101;
            default: alu_of = 5'b01110;
        endcase
    endfunction

    function automatic logic [4:0] br_alu(input logic [2:0] f3);
        case (f3)
            3'd0:    br_alu = 5'b00100;
            3'd1:    br_alu = 5'b00101;
            3'd4:    br_alu = 5'b00110;
            3'd5:    br_alu = 5'b00111;
            3'd6:    br_alu = 5'b01000;
            default: br_alu = 5'b01001;
        endcase
    endfunction

    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    ctl_t       dec;
    ctl_t       ex_q;
    logic       uses_rs1;
    logic       uses_rs2;
    logic [CNT_W-1:0] cnt;
    logic       adv;
    logic       haz;
    logic       mbusy;
    logic       take;

    assign opc = id_instr[6:0];
    assign f3  = id_instr[14:12];
    assign f7  = id_instr[31:25];

    always_comb begin
        dec      = '0;
        dec.rs1  = id_instr[19:15];
        dec.rs2  = id_instr[24:20];
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b0;
        case (opc)
            OP_R: begin
                if (MDU_EN != 0 && f7 == 7'b0000001) begin
                    dec.mdu   = 1'b1;
                    dec.regw  = 1'b1;
                    dec.mduop = f3;
                    uses_rs2  = 1'b1;
                end else if (f7 == 7'b0 || (f7 == 7'b0100000 && (f3 == 3'd0 || f3 == 3'd5))) begin
                    dec.regw = 1'b1;
                    dec.alu  = alu_of(f3, f7[5]);
                    uses_rs2 = 1'b1;
                end else begin
                    dec.ill = 1'b1;
                end
            end
            OP_I: begin
                dec.regw   = 1'b1;
                dec.alusrc = 1'b1;
                dec.ext    = EXT_I;
                dec.alu    = alu_of(f3, 1'b0);
                if (f3 == 3'd1 || f3 == 3'd5) begin
                    dec.ext = EXT_SHAMT;
                    dec.alu = alu_of(f3, f7[5]);
                    if (!(f7 == 7'b0 || (f3 == 3'd5 && f7 == 7'b0100000)))
                        dec.ill = 1'b1;
                end
            end
            OP_L: begin
                if (f3 == 3'd2) begin
                    dec.regw   = 1'b1;
                    dec.memr   = 1'b1;
                    dec.alusrc = 1'b1;
                    dec.ext    = EXT_I;
                    dec.alu    = ALU_ADD;
                    dec.wd     = WD_MEM;
                end else begin
                    dec.ill = 1'b1;
                end
            end
            OP_S: begin
                if (f3 == 3'd2) begin
                    dec.memw   = 1'b1;
                    dec.alusrc = 1'b1;
                    dec.ext    = EXT_S;
                    dec.alu    = ALU_ADD;
                    uses_rs2   = 1'b1;
                end else begin
                    dec.ill = 1'b1;
                end
            end
            OP_B: begin
                if (f3 == 3'd2 || f3 == 3'd3) begin
                    dec.ill = 1'b1;
                end else begin
                    dec.ext  = EXT_B;
                    dec.npc  = NPC_BR;
                    dec.alu  = br_alu(f3);
                    uses_rs2 = 1'b1;
                end
            end
            OP_JAL: begin
                dec.regw = 1'b1;
                dec.ext  = EXT_J;
                dec.npc  = NPC_JAL;
                dec.wd   = WD_PC;
                uses_rs1 = 1'b0;
            end
            OP_JALR: begin
                if (f3 == 3'd0) begin
                    dec.regw   = 1'b1;
                    dec.alusrc = 1'b1;
                    dec.ext    = EXT_I;
                    dec.alu    = ALU_ADD;
                    dec.npc    = NPC_JALR;
                    dec.wd     = WD_PC;
                end else begin
                    dec.ill = 1'b1;
                end
            end
            OP_LUI: begin
                dec.regw   = 1'b1;
                dec.alusrc = 1'b1;
                dec.ext    = EXT_U;
                dec.alu    = ALU_LUI;
                uses_rs1   = 1'b0;
            end
            default: dec.ill = 1'b1;
        endcase
        // Illegal encodings carry no side effects but still flow down the pipe.
        if (dec.ill) begin
            dec.regw   = 1'b0;
            dec.memw   = 1'b0;
            dec.memr   = 1'b0;
            dec.alusrc = 1'b0;
            dec.ext    = '0;
            dec.alu    = '0;
            dec.npc    = '0;
            dec.wd     = '0;
            dec.mdu    = 1'b0;
            dec.mduop  = '0;
            uses_rs2   = 1'b0;
        end
        dec.rd = dec.regw ? id_instr[11:7] : 5'd0;
    end

    assign adv   = ~ex_valid | ex_ready;
    assign haz   = ex_valid & ex_q.memr & (ex_q.rd != 5'd0) &
                   ((uses_rs1 & (dec.rs1 == ex_q.rd)) | (uses_rs2 & (dec.rs2 == ex_q.rd)));
    assign mbusy = (cnt != '0);
    assign id_ready = flush | (adv & ~haz & ~mbusy);
    assign take  = id_valid & ~flush & adv & ~haz & ~mbusy;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ex_valid <= 1'b0;
            ex_q     <= '0;
            cnt      <= '0;
        end else begin
            if (take && dec.mdu)
                cnt <= CNT_LOAD;
            else if (cnt != '0)
                cnt <= cnt - CNT_W'(1);
            if (adv || flush) begin
                if (take) begin
                    ex_valid <= 1'b1;
                    ex_q     <= dec;
                end else begin
                    ex_valid <= 1'b0;
                    ex_q     <= '0;
                end
            end
        end
    end

    assign ex_rd       = ex_q.rd;
    assign ex_rs1      = ex_q.rs1;
    assign ex_rs2      = ex_q.rs2;
    assign ex_RegWrite = ex_q.regw;
    assign ex_MemWrite = ex_q.memw;
    assign ex_MemRead  = ex_q.memr;
    assign ex_ALUSrc   = ex_q.alusrc;
    assign ex_EXTOp    = ex_q.ext;
    assign ex_ALUOp    = ex_q.alu;
    assign ex_NPCOp    = ex_q.npc;
    assign ex_WDSel    = ex_q.wd;
    assign ex_mdu      = ex_q.mdu;
    assign ex_MDUOp    = ex_q.mduop;
    assign ex_illegal  = ex_q.ill;
endmodule

// File: tb/tb_ctrl_pipe.sv
// tb/tb_ctrl_pipe.sv - randomized self-checking bench for ctrl_pipe against a mnemonic-level model
module tb_ctrl_pipe;
    localparam int MDU_LAT = 4;

    logic        clk = 1'b0;
    logic        rstn;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_instr;
    logic        ex_ready;
    logic        flush;
    logic        ex_valid;
    logic [4:0]  ex_rd, ex_rs1, ex_rs2;
    logic        ex_RegWrite, ex_MemWrite, ex_MemRead, ex_ALUSrc;
    logic [5:0]  ex_EXTOp;
    logic [4:0]  ex_ALUOp, ex_NPCOp;
    logic [1:0]  ex_WDSel;
    logic        ex_mdu;
    logic [2:0]  ex_MDUOp;
    logic        ex_illegal;

    ctrl_pipe #(.MDU_EN(1), .MDU_LAT(MDU_LAT), .CNT_W(6)) dut (
        .clk(clk), .rstn(rstn), .id_valid(id_valid), .id_ready(id_ready),
        .id_instr(id_instr), .ex_ready(ex_ready), .flush(flush),
        .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
        .ex_RegWrite(ex_RegWrite), .ex_MemWrite(ex_MemWrite), .ex_MemRead(ex_MemRead),
        .ex_ALUSrc(ex_ALUSrc), .ex_EXTOp(ex_EXTOp), .ex_ALUOp(ex_ALUOp),
        .ex_NPCOp(ex_NPCOp), .ex_WDSel(ex_WDSel), .ex_mdu(ex_mdu),
        .ex_MDUOp(ex_MDUOp), .ex_illegal(ex_illegal)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd, rs1, rs2;
        logic       regw, memw, memr, alusrc;
        logic [5:0] ext;
        logic [4:0] alu, npc;
        logic [1:0] wd;
        logic       mdu;
        logic [2:0] mduop;
        logic       illegal;
    } exp_t;

    // Mnemonic tables: add sub sll slt sltu xor srl sra or and
    localparam logic [2:0] AL_F3 [10] = '{3'd0, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd5, 3'd6, 3'd7};
    localparam logic [6:0] AL_F7 [10] = '{7'h00, 7'h20, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h20, 7'h00, 7'h00};
    localparam logic [4:0] AL_OP [10] = '{5'd3, 5'd4, 5'd15, 5'd10, 5'd11, 5'd12, 5'd16, 5'd17, 5'd13, 5'd14};
    localparam int         I_IDX [9]  = '{0, 3, 4, 5, 8, 9, 2, 6, 7};
    localparam logic [2:0] B_F3  [6]  = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};

    int   n_chk = 0;
    int   n_pass = 0;
    logic m_valid;
    exp_t m_e;
    int   cyc;
    int   busy_until;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    endtask

    function automatic exp_t observed();
        return {ex_valid, ex_rd, ex_rs1, ex_rs2, ex_RegWrite, ex_MemWrite, ex_MemRead,
                ex_ALUSrc, ex_EXTOp, ex_ALUOp, ex_NPCOp, ex_WDSel, ex_mdu, ex_MDUOp, ex_illegal};
    endfunction

    // k: 0-9 R-ALU, 10-18 I-ALU, 19 lw, 20 sw, 21-26 branches, 27 jal, 28 jalr,
    // 29 lui, 30 M-ext, 31-33 illegal encodings.
    task automatic gen(input int k, input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                       output logic [31:0] w, output exp_t e, output logic u1, output logic u2);
        logic [6:0] op, f7;
        logic [2:0] f3;
        logic       has_f3, has_f7;
        int         idx;
        w = $urandom;
        e = '0; e.valid = 1'b1; e.rs1 = rs1; e.rs2 = rs2;
        u1 = 1'b1; u2 = 1'b0; has_f3 = 1'b1; has_f7 = 1'b0;
        op = 7'h33; f3 = 3'd0; f7 = 7'h00;
        if (k <= 9) begin
            f3 = AL_F3[k]; f7 = AL_F7[k]; has_f7 = 1'b1; u2 = 1'b1;
            e.regw = 1'b1; e.alu = AL_OP[k];
        end else if (k <= 18) begin
            idx = I_IDX[k - 10];
            op = 7'h13; f3 = AL_F3[idx];
            e.regw = 1'b1; e.alusrc = 1'b1; e.alu = AL_OP[idx]; e.ext = 6'b010000;
            if (f3 == 3'd1 || f3 == 3'd5) begin
                has_f7 = 1'b1; f7 = AL_F7[idx]; e.ext = 6'b100000;
            end
        end else if (k >= 21 && k <= 26) begin
            op = 7'h63; f3 = B_F3[k - 21];
            e.alu = 5'(4 + k - 21); e.ext = 6'b000100; e.npc = 5'd1; u2 = 1'b1;
        end else begin
            case (k)
                19: begin op = 7'h03; f3 = 3'd2; e.regw = 1; e.memr = 1; e.alusrc = 1;
                          e.ext = 6'b010000; e.alu = 5'd3; e.wd = 2'b01; end
                20: begin op = 7'h23; f3 = 3'd2; e.memw = 1; e.alusrc = 1;
                          e.ext = 6'b001000; e.alu = 5'd3; u2 = 1; end
                27: begin op = 7'h6F; has_f3 = 0; e.regw = 1; e.ext = 6'b000001;
                          e.npc = 5'd2; e.wd = 2'b10; u1 = 0; end
                28: begin op = 7'h67; f3 = 3'd0; e.regw = 1; e.alusrc = 1; e.ext = 6'b010000;
                          e.alu = 5'd3; e.npc = 5'd4; e.wd = 2'b10; end
                29: begin op = 7'h37; has_f3 = 0; e.regw = 1; e.alusrc = 1;
                          e.ext = 6'b000010; e.alu = 5'd1; u1 = 0; end
                30: begin f3 = 3'($urandom_range(0, 7)); has_f7 = 1; f7 = 7'h01;
                          e.regw = 1; e.mdu = 1; e.mduop = f3; u2 = 1; end
                31: begin op = 7'h7F; has_f3 = 0; e.illegal = 1; end
                32: begin op = 7'h63; f3 = 3'd2; e.illegal = 1; end
                default: begin has_f7 = 1; f7 = 7'h02; e.illegal = 1; end
            endcase
        end
        e.rd = e.regw ? rd : 5'd0;
        w[6:0] = op; w[11:7] = rd; w[19:15] = rs1; w[24:20] = rs2;
        if (has_f3) w[14:12] = f3;
        if (has_f7) w[31:25] = f7;
    endtask

    task automatic step(input logic iv, input int k, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic er, input logic fl);
        logic [31:0] w;
        exp_t        ce;
        logic        u1, u2, adv, haz, busy, rdy;
        gen(k, rd, rs1, rs2, w, ce, u1, u2);
        @(negedge clk);
        if (m_valid) check("ex_fields", 64'(observed()), 64'(m_e));
        else         check("ex_valid", 64'(ex_valid), 64'(0));
        id_valid = iv; id_instr = w; ex_ready = er; flush = fl;
        #1;
        adv  = !m_valid || er;
        haz  = m_valid && m_e.memr && (m_e.rd != 5'd0) &&
               ((u1 && rs1 == m_e.rd) || (u2 && rs2 == m_e.rd));
        busy = cyc < busy_until;
        rdy  = fl || (adv && !haz && !busy);
        check("id_ready", 64'(id_ready), 64'(rdy));
        if (fl) begin
            m_valid = 1'b0; m_e = '0;
        end else if (adv) begin
            if (iv && !haz && !busy) begin
                m_valid = 1'b1; m_e = ce;
                if (ce.mdu) busy_until = cyc + MDU_LAT;
            end else begin
                m_valid = 1'b0; m_e = '0;
            end
        end
        cyc++;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rstn = 1'b0;
        #1;
        check("rst_ex", 64'(observed()), 64'(0));
        check("rst_id_ready", 64'(id_ready), 64'(1));
        id_valid = 1'b0; flush = 1'b0; ex_ready = 1'b1;
        @(negedge clk);
        rstn = 1'b1;
        m_valid = 1'b0; m_e = '0; busy_until = 0; cyc = 0;
    endtask

    initial begin
        rstn = 1'b0; id_valid = 1'b0; id_instr = 32'h0; ex_ready = 1'b0; flush = 1'b0;
        m_valid = 1'b0; m_e = '0; cyc = 0; busy_until = 0;
        @(negedge clk);
        check("reset_ex", 64'(observed()), 64'(0));
        @(negedge clk);
        rstn = 1'b1;

        step(1, 0, 5'd3, 5'd1, 5'd2, 1, 0);        // add x3,x1,x2 = 0x002081B3
        step(1, 19, 5'd5, 5'd1, 5'd0, 1, 0);       // lw x5
        step(1, 0, 5'd6, 5'd5, 5'd2, 1, 0);        // add x6,x5,x2 -> stall
        step(1, 0, 5'd6, 5'd5, 5'd2, 1, 0);
        step(1, 19, 5'd0, 5'd1, 5'd0, 1, 0);       // lw x0
        step(1, 0, 5'd6, 5'd0, 5'd2, 1, 0);
        step(1, 19, 5'd5, 5'd1, 5'd0, 1, 0);       // lw x5 then lui x5
        step(1, 29, 5'd5, 5'd5, 5'd5, 1, 0);
        step(1, 21, 5'd0, 5'd1, 5'd2, 1, 0);       // beq, then flush
        step(1, 0, 5'd7, 5'd1, 5'd2, 1, 1);
        step(1, 5, 5'd7, 5'd1, 5'd2, 1, 0);
        step(1, 0, 5'd7, 5'd1, 5'd2, 0, 1);        // flush under back-pressure
        step(1, 30, 5'd8, 5'd1, 5'd2, 1, 0);       // mul then adds
        for (int i = 0; i < 5; i++) step(1, 0, 5'd9, 5'd1, 5'd2, 1, 0);
        step(1, 0, 5'd3, 5'd1, 5'd2, 1, 0);
        for (int i = 0; i < 5; i++) step(1, 5, 5'd4, 5'd1, 5'd2, 0, 0);
        step(1, 31, 5'd4, 5'd1, 5'd2, 1, 0);       // opcode 0x7F
        step(1, 32, 5'd4, 5'd1, 5'd2, 0, 0);
        step(1, 33, 5'd4, 5'd1, 5'd2, 0, 0);
        pulse_reset();
        step(1, 30, 5'd8, 5'd1, 5'd2, 1, 0);       // mul, then reset discards occupancy
        step(1, 0, 5'd9, 5'd1, 5'd2, 1, 0);
        pulse_reset();
        step(1, 0, 5'd9, 5'd1, 5'd2, 1, 0);
        step(0, 0, 5'd9, 5'd1, 5'd2, 1, 0);

        for (int i = 0; i < 800; i++) begin
            step($urandom_range(0, 3) != 0, int'($urandom_range(0, 33)),
                 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                 $urandom_range(0, 9) < 7, $urandom_range(0, 11) == 0);
        end
        step(0, 0, 5'd0, 5'd0, 5'd0, 1, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
